// File: rtl/disp_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// disp_ctrl_pkg
// Shared definitions for the key-driven display-window controller:
//   - window adjustment mode encoding (SIZE / POS)
//   - key index assignments for the action and mode keys
//   - per-key debounce / auto-repeat FSM state encoding
// ---------------------------------------------------------------------------
package disp_ctrl_pkg;

  localparam logic MODE_SIZE = 1'b0;
  localparam logic MODE_POS  = 1'b1;

  localparam int KEY_XP   = 0;
  localparam int KEY_XN   = 1;
  localparam int KEY_YP   = 2;
  localparam int KEY_YN   = 3;
  localparam int KEY_MODE = 4;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_t;

endpackage

// File: rtl/key_debounce_repeat.sv
// ---------------------------------------------------------------------------
// key_debounce_repeat
// One active-low push-button: 2-FF synchronizer, debounce FSM and
// hold-to-repeat timer.
// Ports:
//   sys_clk    in  clock
//   sys_rst_n  in  asynchronous active-low reset
//   i_key_n    in  raw key, active-low, asynchronous to sys_clk
//   o_event    out one-cycle pulse on acceptance and on every auto-repeat
//   o_accept   out one-cycle pulse on acceptance only
// ---------------------------------------------------------------------------
module key_debounce_repeat
  import disp_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int REPEAT_DLY   = 25_000_000,
  parameter int REPEAT_PER   = 5_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_key_n,
  output logic o_event,
  output logic o_accept
);

  localparam int MAX_A = (DEBOUNCE_CYC > REPEAT_DLY) ? DEBOUNCE_CYC : REPEAT_DLY;
  localparam int MAX_C = (MAX_A > REPEAT_PER) ? MAX_A : REPEAT_PER;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] C_DB  = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] C_DLY = CNT_W'(REPEAT_DLY);
  localparam logic [CNT_W-1:0] C_PER = CNT_W'(REPEAT_PER);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic             r_s1;
  logic             r_s2;
  db_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rep;
  logic             r_event;
  logic             r_accept;

  // Synchronizers reset to "released" so a key held through reset is seen
  // as a fresh press and must pass the full debounce afterwards.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_rep    <= 1'b0;
      r_event  <= 1'b0;
      r_accept <= 1'b0;
    end else begin
      r_s1     <= i_key_n;
      r_s2     <= r_s1;
      r_event  <= 1'b0;
      r_accept <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!r_s2) begin
            r_state <= ST_PRESS_WAIT;
            r_cnt   <= C_ONE;
          end
        end
        ST_PRESS_WAIT: begin
          // A high sample is a bounce: drop back and restart the count.
          if (r_s2) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == C_DB) begin
            r_state  <= ST_HELD;
            r_cnt    <= C_ONE;
            r_rep    <= 1'b0;
            r_event  <= 1'b1;
            r_accept <= 1'b1;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        ST_HELD: begin
          if (r_s2) begin
            r_state <= ST_RELEASE_WAIT;
            r_cnt   <= C_ONE;
          end else if ((!r_rep && r_cnt == C_DLY) || (r_rep && r_cnt == C_PER)) begin
            r_cnt   <= C_ONE;
            r_rep   <= 1'b1;
            r_event <= 1'b1;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        ST_RELEASE_WAIT: begin
          if (!r_s2) begin
            r_cnt <= '0;
          end else if (r_cnt == C_DB) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_event  = r_event;
  assign o_accept = r_accept;

endmodule

// File: rtl/disp_window_ctrl.sv
// ---------------------------------------------------------------------------
// disp_window_ctrl
// Key-driven display window controller. Debounced key events adjust staged
// width/height/offset values; staging is committed to the outputs on the
// rising edge of the HDMI frame-end flag so a frame never tears.
// Ports:
//   sys_clk      in  clock
//   sys_rst_n    in  asynchronous active-low reset
//   key          in  raw keys, active-low (0:+X 1:-X 2:+Y 3:-Y 4:mode)
//   i_frame_end  in  frame-complete level from the HDMI timing block
//   o_disp_w/h   out committed window width / height
//   o_disp_x/y   out committed left / top offset
//   o_mode       out 0 = SIZE, 1 = POS
//   o_update     out one-cycle pulse when a commit changes any value
// ---------------------------------------------------------------------------
module disp_window_ctrl
  import disp_ctrl_pkg::*;
#(
  parameter int KEY_NUM      = 5,
  parameter int HDMI_W       = 1920,
  parameter int HDMI_H       = 1080,
  parameter int MIN_W        = 250,
  parameter int MIN_H        = 250,
  parameter int STEP         = 10,
  parameter int IMAGE_WIDTH  = 11,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int REPEAT_DLY   = 25_000_000,
  parameter int REPEAT_PER   = 5_000_000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [KEY_NUM-1:0]     key,
  input  logic                   i_frame_end,
  output logic [IMAGE_WIDTH-1:0] o_disp_w,
  output logic [IMAGE_WIDTH-1:0] o_disp_h,
  output logic [IMAGE_WIDTH-1:0] o_disp_x,
  output logic [IMAGE_WIDTH-1:0] o_disp_y,
  output logic                   o_mode,
  output logic                   o_update
);

  // One guard bit so sums and differences never wrap before clamping.
  typedef logic [IMAGE_WIDTH:0] ext_t;

  localparam ext_t C_HW   = ext_t'(HDMI_W);
  localparam ext_t C_HH   = ext_t'(HDMI_H);
  localparam ext_t C_MW   = ext_t'(MIN_W);
  localparam ext_t C_MH   = ext_t'(MIN_H);
  localparam ext_t C_STEP = ext_t'(STEP);
  localparam ext_t C_ZERO = '0;
  localparam int   SEL_W  = $clog2(KEY_NUM);

  localparam logic [KEY_NUM-1:0] MODE_MASK = {{(KEY_NUM-1){1'b0}}, 1'b1} << KEY_MODE;

  function automatic ext_t sat_add(input ext_t a, input ext_t b, input ext_t hi);
    ext_t s;
    s = a + b;
    return (s > hi) ? hi : s;
  endfunction

  function automatic ext_t sat_sub(input ext_t a, input ext_t b, input ext_t lo);
    return (a < lo + b) ? lo : a - b;
  endfunction

  logic [KEY_NUM-1:0]     w_event;
  logic [KEY_NUM-1:0]     w_accept;
  logic [KEY_NUM-1:0]     w_req;
  logic [SEL_W-1:0]       w_sel;
  ext_t                   w_nw, w_nh, w_nx, w_ny;
  logic                   w_nmode;

  logic [IMAGE_WIDTH-1:0] r_w, r_h, r_x, r_y;
  logic                   r_mode;
  logic [IMAGE_WIDTH-1:0] r_out_w, r_out_h, r_out_x, r_out_y;
  logic                   r_upd;
  logic                   r_fe_q1, r_fe_q2;

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
    key_debounce_repeat #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DLY   (REPEAT_DLY),
      .REPEAT_PER   (REPEAT_PER)
    ) u_key (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .i_key_n   (key[g]),
      .o_event   (w_event[g]),
      .o_accept  (w_accept[g])
    );
  end

  // The mode key acts on acceptance only; every other key uses the
  // repeating event stream.
  assign w_req = (w_event & ~MODE_MASK) | (w_accept & MODE_MASK);

  // Stage 0: arbitrate (lowest index wins) and compute next staging values.
  always_comb begin
    w_nw    = {1'b0, r_w};
    w_nh    = {1'b0, r_h};
    w_nx    = {1'b0, r_x};
    w_ny    = {1'b0, r_y};
    w_nmode = r_mode;
    w_sel   = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (w_req[i]) w_sel = SEL_W'(i);
    end
    if (|w_req) begin
      if (w_sel == SEL_W'(KEY_MODE)) begin
        w_nmode = ~r_mode;
      end else if (r_mode == MODE_SIZE) begin
        if (w_sel == SEL_W'(KEY_XP))      w_nw = sat_add(w_nw, C_STEP, C_HW);
        else if (w_sel == SEL_W'(KEY_XN)) w_nw = sat_sub(w_nw, C_STEP, C_MW);
        else if (w_sel == SEL_W'(KEY_YP)) w_nh = sat_add(w_nh, C_STEP, C_HH);
        else if (w_sel == SEL_W'(KEY_YN)) w_nh = sat_sub(w_nh, C_STEP, C_MH);
        // A grown window pulls its offset back so it stays inside the raster.
        if (w_nx + w_nw > C_HW) w_nx = C_HW - w_nw;
        if (w_ny + w_nh > C_HH) w_ny = C_HH - w_nh;
      end else begin
        if (w_sel == SEL_W'(KEY_XP))      w_nx = sat_add(w_nx, C_STEP, C_HW - w_nw);
        else if (w_sel == SEL_W'(KEY_XN)) w_nx = sat_sub(w_nx, C_STEP, C_ZERO);
        else if (w_sel == SEL_W'(KEY_YP)) w_ny = sat_add(w_ny, C_STEP, C_HH - w_nh);
        else if (w_sel == SEL_W'(KEY_YN)) w_ny = sat_sub(w_ny, C_STEP, C_ZERO);
      end
    end
  end

  // Stage 1: staging registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_w    <= IMAGE_WIDTH'(HDMI_W);
      r_h    <= IMAGE_WIDTH'(HDMI_H);
      r_x    <= '0;
      r_y    <= '0;
      r_mode <= MODE_SIZE;
    end else begin
      r_w    <= w_nw[IMAGE_WIDTH-1:0];
      r_h    <= w_nh[IMAGE_WIDTH-1:0];
      r_x    <= w_nx[IMAGE_WIDTH-1:0];
      r_y    <= w_ny[IMAGE_WIDTH-1:0];
      r_mode <= w_nmode;
    end
  end

  // Stage 2: frame-end edge detect and commit. The edge is seen one cycle
  // after the high sample, so staging written on the commit edge itself
  // waits for the next frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_fe_q1 <= 1'b0;
      r_fe_q2 <= 1'b0;
      r_out_w <= IMAGE_WIDTH'(HDMI_W);
      r_out_h <= IMAGE_WIDTH'(HDMI_H);
      r_out_x <= '0;
      r_out_y <= '0;
      r_upd   <= 1'b0;
    end else begin
      r_fe_q1 <= i_frame_end;
      r_fe_q2 <= r_fe_q1;
      r_upd   <= 1'b0;
      if (r_fe_q1 && !r_fe_q2) begin
        r_out_w <= r_w;
        r_out_h <= r_h;
        r_out_x <= r_x;
        r_out_y <= r_y;
        r_upd   <= (r_w != r_out_w) || (r_h != r_out_h) ||
                   (r_x != r_out_x) || (r_y != r_out_y);
      end
    end
  end

  assign o_disp_w = r_out_w;
  assign o_disp_h = r_out_h;
  assign o_disp_x = r_out_x;
  assign o_disp_y = r_out_y;
  assign o_mode   = r_mode;
  assign o_update = r_upd;

endmodule

// File: tb/tb_disp_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_disp_window_ctrl
// Directed bench for disp_window_ctrl. Two instances share clock, reset and
// frame_end: dut A uses the default raster, dut B a 1925-wide raster so a
// width of 255 (not a multiple of the step) is reachable for the exact-clamp
// case. Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_disp_window_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  key_a = 5'h1f;
  logic [4:0]  key_b = 5'h1f;
  logic        fe = 1'b0;
  logic [10:0] w_a, h_a, x_a, y_a, w_b, h_b, x_b, y_b;
  logic        m_a, m_b, u_a, u_b;

  int total = 0;
  int bad = 0;
  int cnt_a = 0;
  int cnt_b = 0;

  always #5 clk = ~clk;

  disp_window_ctrl #(
    .KEY_NUM(5), .HDMI_W(1920), .HDMI_H(1080), .MIN_W(250), .MIN_H(250),
    .STEP(10), .IMAGE_WIDTH(11), .DEBOUNCE_CYC(4), .REPEAT_DLY(20), .REPEAT_PER(5)
  ) u_dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .key(key_a), .i_frame_end(fe),
    .o_disp_w(w_a), .o_disp_h(h_a), .o_disp_x(x_a), .o_disp_y(y_a),
    .o_mode(m_a), .o_update(u_a)
  );

  disp_window_ctrl #(
    .KEY_NUM(5), .HDMI_W(1925), .HDMI_H(1080), .MIN_W(250), .MIN_H(250),
    .STEP(10), .IMAGE_WIDTH(11), .DEBOUNCE_CYC(4), .REPEAT_DLY(20), .REPEAT_PER(5)
  ) u_dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .key(key_b), .i_frame_end(fe),
    .o_disp_w(w_b), .o_disp_h(h_b), .o_disp_x(x_b), .o_disp_y(y_b),
    .o_mode(m_b), .o_update(u_b)
  );

  always @(negedge clk) begin
    if (u_a) cnt_a++;
    if (u_b) cnt_b++;
  end

  typedef struct {
    int d;  int k;  int n;
    int ew; int eh; int ex; int ey; int em; int eu;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int d, input int ew, input int eh,
                          input int ex, input int ey, input int em);
    if (d == 0) begin
      chk({tag, ".w"}, int'(w_a), ew);
      chk({tag, ".h"}, int'(h_a), eh);
      chk({tag, ".x"}, int'(x_a), ex);
      chk({tag, ".y"}, int'(y_a), ey);
      chk({tag, ".mode"}, int'(m_a), em);
    end else begin
      chk({tag, ".w"}, int'(w_b), ew);
      chk({tag, ".h"}, int'(h_b), eh);
      chk({tag, ".x"}, int'(x_b), ex);
      chk({tag, ".y"}, int'(y_b), ey);
      chk({tag, ".mode"}, int'(m_b), em);
    end
  endtask

  // Single frame_end pulse; reports o_update pulses seen per dut.
  task automatic frame(output int da, output int db);
    int sa, sb;
    @(negedge clk);
    sa = cnt_a;
    sb = cnt_b;
    fe = 1'b1;
    @(negedge clk);
    fe = 1'b0;
    repeat (3) @(negedge clk);
    da = cnt_a - sa;
    db = cnt_b - sb;
  endtask

  // Hold key k of dut d long enough for exactly n events, then release
  // and let the release debounce finish. Events land at edges 6, 26, 31, ...
  task automatic hold_key(input int d, input int k, input int n);
    int last;
    last = (n == 1) ? 6 : 26 + 5 * (n - 2);
    for (int c = 0; c <= last + 14; c++) begin
      @(negedge clk);
      if (d == 0) key_a[k] = (c <= last) ? 1'b0 : 1'b1;
      else        key_b[k] = (c <= last) ? 1'b0 : 1'b1;
    end
  endtask

  initial begin
    int da, db, sa;

    tbl[0]  = '{0, 1,   1,  250, 1080,   0,  0, 0, 0};
    tbl[1]  = '{1, 1,   1,  250, 1080,   0,  0, 0, 1};
    tbl[2]  = '{1, 1,   1,  250, 1080,   0,  0, 0, 0};
    tbl[3]  = '{0, 0,  75, 1000, 1080,   0,  0, 0, 1};
    tbl[4]  = '{0, 4,   1, 1000, 1080,   0,  0, 1, 0};
    tbl[5]  = '{0, 0, 100, 1000, 1080, 920,  0, 1, 1};
    tbl[6]  = '{0, 0,   1, 1000, 1080, 920,  0, 1, 0};
    tbl[7]  = '{0, 4,   1, 1000, 1080, 920,  0, 0, 0};
    tbl[8]  = '{0, 0,   5, 1050, 1080, 870,  0, 0, 1};
    tbl[9]  = '{0, 3,   3, 1050, 1050, 870,  0, 0, 1};
    tbl[10] = '{0, 4,   1, 1050, 1050, 870,  0, 1, 0};
    tbl[11] = '{0, 2,   4, 1050, 1050, 870, 30, 1, 1};
    tbl[12] = '{0, 1, 100, 1050, 1050,   0, 30, 1, 1};
    tbl[13] = '{0, 4,   1, 1050, 1050,   0, 30, 0, 0};
    tbl[14] = '{0, 2,   1, 1050, 1060,   0, 20, 0, 1};
    tbl[15] = '{0, 1,  80,  250, 1060,   0, 20, 0, 1};

    // Reset state and idle frames
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_outs("reset", 0, 1920, 1080, 0, 0, 0);
    chk("reset.upd", int'(u_a), 0);
    for (int i = 0; i < 3; i++) frame(da, db);
    chk_outs("idle", 0, 1920, 1080, 0, 0, 0);
    chk("idle.upd_cnt", cnt_a, 0);

    // Long key1 hold with one bounce (dut A); dut B held to exactly 255
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c == 22) begin
        chk("hold.first_commit.w", int'(w_a), 1910);
        chk("hold.first_commit.upd", int'(u_a), 1);
      end
      if (c == 32) chk("hold.no_early_commit.w", int'(w_a), 1910);
      if (c == 33) chk("hold.first_repeat.w", int'(w_a), 1900);
      if (c == 38) chk("hold.period.w", int'(w_a), 1890);
      key_a[1] = (c == 2) ? 1'b1 : 1'b0;
      key_b[1] = (c >= 852) ? 1'b1 : 1'b0;
      fe = (c == 20 || c == 31 || c == 36) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    key_a[1] = 1'b1;
    fe = 1'b0;
    repeat (20) @(negedge clk);
    frame(da, db);
    chk("hold.sat_min.w", int'(w_a), 250);
    chk("hold.sat_min.upd", da, 1);
    chk("b.reach255.w", int'(w_b), 255);

    // Table-driven presses, one frame commit per row
    for (int r = 0; r < 16; r++) begin
      hold_key(tbl[r].d, tbl[r].k, tbl[r].n);
      frame(da, db);
      chk_outs($sformatf("row%0d", r), tbl[r].d, tbl[r].ew, tbl[r].eh,
               tbl[r].ex, tbl[r].ey, tbl[r].em);
      chk($sformatf("row%0d.upd", r), (tbl[r].d == 0) ? da : db, tbl[r].eu);
    end

    // key0 and key2 accepted together: only width moves
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      key_a[0] = (c <= 7) ? 1'b0 : 1'b1;
      key_a[2] = (c <= 7) ? 1'b0 : 1'b1;
    end
    frame(da, db);
    chk_outs("simul", 0, 260, 1060, 0, 20, 0);
    chk("simul.upd", da, 1);

    // key1 event on the same edge the frame_end rise is sampled
    sa = cnt_a;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      key_a[1] = (c <= 7) ? 1'b0 : 1'b1;
      fe = (c == 6) ? 1'b1 : 1'b0;
    end
    chk("sameframe.w", int'(w_a), 260);
    chk("sameframe.upd_cnt", cnt_a - sa, 0);
    frame(da, db);
    chk("nextframe.w", int'(w_a), 250);
    chk("nextframe.upd", da, 1);

    // Reset asserted during auto-repeat with the key still held
    for (int c = 0; c <= 60; c++) begin
      @(negedge clk);
      if (c == 41) begin
        chk_outs("midrst", 0, 1920, 1080, 0, 0, 0);
        chk("midrst.upd", int'(u_a), 0);
      end
      if (c == 50) begin
        chk("postrst.no_early.w", int'(w_a), 1920);
        chk("postrst.no_early.upd", int'(u_a), 0);
      end
      if (c == 52) begin
        chk("postrst.event.w", int'(w_a), 1910);
        chk("postrst.event.upd", int'(u_a), 1);
      end
      key_a[1] = (c <= 55) ? 1'b0 : 1'b1;
      rst_n = (c == 40 || c == 41) ? 1'b0 : 1'b1;
      fe = (c == 48 || c == 50) ? 1'b1 : 1'b0;
    end
    fe = 1'b0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_window_ctrl.md
# disp_window_ctrl

Key-driven display-window controller: debounces KEY_NUM active-low push-buttons, supports hold-to-auto-repeat, and maintains a clamped display window: width, height, and X/Y offset inside the HDMI raster. Sits between the board keys and the HDMI output/scaler path. Window updates are staged and committed only on the rising edge of the HDMI frame-end flag, so a frame never tears.

## Interface
- KEY_NUM, 5: number of keys, ≥5. Keys 0–3 are +X/−X/+Y/−Y actions; key 4 is mode toggle; extra keys are debounced and ignored.
- HDMI_W, 1920: raster width; maximum window width.
- HDMI_H, 1080: raster height; maximum window height.
- MIN_W, 250: minimum window width.
- MIN_H, 250: minimum window height.
- STEP, 10: increment per key event, in pixels.
- IMAGE_WIDTH, 11: width of all size/offset values.
- DEBOUNCE_CYC, 1_000_000: cycles a key must be stable before it is accepted.
- REPEAT_DLY, 25_000_000: hold time after acceptance before the first auto-repeat.
- REPEAT_PER, 5_000_000: auto-repeat period.

Ports:
- sys_clk, in, 1: clock.
- sys_rst_n, in, 1: reset, asynchronous, active-low.
- key, in, KEY_NUM: raw buttons, active-low, asynchronous to sys_clk.
- i_frame_end, in, 1: frame-complete level from the HDMI timing block (sys_clk domain).
- o_disp_w, out, IMAGE_WIDTH: committed window width.
- o_disp_h, out, IMAGE_WIDTH: committed window height.
- o_disp_x, out, IMAGE_WIDTH: committed left offset.
- o_disp_y, out, IMAGE_WIDTH: committed top offset.
- o_mode, out, 1: 0 = SIZE, 1 = POS.
- o_update, out, 1: one-cycle pulse when committed values change.

## Operation
- Each key passes through a 2-FF synchronizer, then a per-key debounce FSM.
  - States: IDLE → PRESS_WAIT (stable low, counting to DEBOUNCE_CYC) → HELD (counting to REPEAT_DLY, then every REPEAT_PER) → RELEASE_WAIT (stable high for DEBOUNCE_CYC) → IDLE.
  - Any input bounce in PRESS_WAIT or RELEASE_WAIT restarts that state's count.
- An event is a one-cycle pulse on acceptance and on each auto-repeat.
- The mode key toggles o_mode on acceptance only; it never auto-repeats.
- Simultaneous events are resolved by fixed priority: lowest index wins; others in that cycle are dropped.
- SIZE mode:
  - key0 raises w by STEP, saturating at HDMI_W; key1 lowers w, saturating at MIN_W.
  - key2 and key3 do the same for h.
  - If x + w_new > HDMI_W, x is set to HDMI_W − w_new in the same cycle; likewise for y.
- POS mode:
  - key0/key1 adjust x by ±STEP, clamped to [0, HDMI_W − w].
  - key2/key3 adjust y the same way, clamped to [0, HDMI_H − h].
- Arithmetic is done in IMAGE_WIDTH+1 bits so saturation never wraps. Non-multiple-of-STEP distances clamp exactly to the limit.
- The staging registers (w, h, x, y) commit to the outputs on the rising edge of i_frame_end.
  - o_update pulses on commit only if any value differs.
  - Staging updated in the same cycle as a commit is taken at the next frame.

## Timing
- Reset values:
  - o_disp_w = HDMI_W, o_disp_h = HDMI_H, o_disp_x = o_disp_y = 0.
  - o_mode = 0, o_update = 0.
  - Staging registers equal the outputs; all FSMs in IDLE with counters at 0.
- Key press latency: the key is low from edge N; the event pulse occurs at edge N + 2 + DEBOUNCE_CYC. Staging updates at +1 cycle.
- Auto-repeat: first repeat event REPEAT_DLY cycles after the acceptance event, then every REPEAT_PER cycles while held.
- Frame commit: i_frame_end is sampled high at edge F with the previous sample low. Outputs and o_update change at edge F+1.
- Reset mid-hold or mid-count returns everything to reset values immediately. A key still held at deassertion must pass the full debounce before producing an event.

## Structure
- Package disp_ctrl_pkg: mode encoding (MODE_SIZE, MODE_POS), key index constants (KEY_XP, KEY_XN, KEY_YP, KEY_YN, KEY_MODE), and the debounce FSM state enum.
- Sub-module key_debounce_repeat: one key, with synchronizer, FSM and counters; instanced KEY_NUM times via generate. Outputs are the event pulse and the accept-only pulse.
- The top level holds the arbiter, staging arithmetic and frame commit.

## Test plan
Bench settings: DEBOUNCE_CYC=4, REPEAT_DLY=20, REPEAT_PER=5, STEP=10.
- Reset, no keys, 3 frame_end pulses → outputs 1920/1080/0/0, mode 0, o_update never asserted.
- key1 low 1000 cycles with a single bounce at cycle 2 → exactly one acceptance event plus repeats at 20, 25, 30… cycles after it. Width decrements by 10 per event, committed only at frame_end edges, and stops at 250.
- Width at 255, key1 pressed → w = 250 (exact clamp, no wrap); further presses leave 250 and produce no o_update.
- Mode → POS; x driven to 1920 − 1000 with w = 1000; then mode → SIZE and key0 ×5 → w = 1050, x = 870.
- key0 and key2 accepted in the same cycle → only w changes; key1 event in the same cycle as a frame_end edge → committed on the following frame.
- Reset asserted during auto-repeat → outputs at reset values next cycle; held key needs a fresh 2 + DEBOUNCE_CYC cycles before its next event.
